// File: rtl/id_inst_buffer_if.sv
// Fetch-to-decode handshake bundle: push side (in_*), pop side (out_*),
// flush and occupancy status. master = fetch/decode side, slave = buffer.
interface id_inst_buffer_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_pc;
  logic [31:0]     in_inst;
  logic            in_br_taken;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [31:0]     out_inst;
  logic            out_br_taken;
  logic            flush;
  logic [CW-1:0]   count;
  logic            almost_full;

  modport master (
    output in_valid, in_pc, in_inst, in_br_taken,
    output out_ready, flush,
    input  in_ready, out_valid, out_pc, out_inst,
    input  out_br_taken, count, almost_full
  );

  modport slave (
    input  in_valid, in_pc, in_inst, in_br_taken,
    input  out_ready, flush,
    output in_ready, out_valid, out_pc, out_inst,
    output out_br_taken, count, almost_full
  );
endinterface

// File: rtl/id_inst_buffer.sv
// DEPTH-entry {pc, inst, br_taken} FIFO between fetch and decode.
// Ports: clk, rst_n (async, active-low), bus (id_inst_buffer_if.slave).
module id_inst_buffer #(
  parameter int          XLEN     = 32,
  parameter int          DEPTH    = 4,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic                clk,
  input  logic                rst_n,
  id_inst_buffer_if.slave     bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     inst;
    logic            br_taken;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          push;
  logic          pop;
  entry_t        head;

  assign bus.in_ready    = (cnt != CW'(DEPTH));
  assign bus.out_valid   = (cnt != '0);
  assign bus.count       = cnt;
  assign bus.almost_full = (cnt >= CW'(DEPTH - 1));

  assign push = bus.in_valid && bus.in_ready;
  assign pop  = bus.out_valid && bus.out_ready;

  assign head = mem[rd_ptr];

  // Empty buffer presents a NOP bubble rather than stale storage.
  always_comb begin
    bus.out_pc       = '0;
    bus.out_inst     = NOP_INST;
    bus.out_br_taken = 1'b0;
    if (bus.out_valid) begin
      bus.out_pc       = head.pc;
      bus.out_inst     = head.inst;
      bus.out_br_taken = head.br_taken;
    end
  end

  // Storage is intentionally not reset; pointers/count define validity.
  always_ff @(posedge clk) begin
    if (push && !bus.flush) begin
      mem[wr_ptr] <= '{pc: bus.in_pc,
                       inst: bus.in_inst,
                       br_taken: bus.in_br_taken};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (bus.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case (1'b1)
        push && !pop: cnt <= cnt + 1'b1;
        pop && !push: cnt <= cnt - 1'b1;
        default:      cnt <= cnt;
      endcase
    end
  end
endmodule

// File: tb/tb_id_inst_buffer.sv
// Self-checking bench for id_inst_buffer: directed scenarios plus
// randomized traffic checked against a queue-based reference model.
module tb_id_inst_buffer;
  localparam int          XLEN  = 32;
  localparam int          DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        br;
  } ent_t;

  logic clk;
  logic rst_n;
  int   cmp;
  int   err;
  ent_t q[$];
  logic [31:0] popped[$];

  id_inst_buffer_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();

  id_inst_buffer #(
    .XLEN(XLEN), .DEPTH(DEPTH), .NOP_INST(NOP)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    cmp++;
    assert (obs === exp) else begin
      err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(string ph);
    int n;
    n = q.size();
    chk({ph, " count"}, 64'(bus.count), 64'(n));
    chk({ph, " out_valid"}, 64'(bus.out_valid), 64'(n != 0));
    chk({ph, " in_ready"}, 64'(bus.in_ready), 64'(n < DEPTH));
    chk({ph, " almost_full"}, 64'(bus.almost_full), 64'(n >= DEPTH - 1));
    if (n != 0) begin
      chk({ph, " out_pc"}, 64'(bus.out_pc), 64'(q[0].pc));
      chk({ph, " out_inst"}, 64'(bus.out_inst), 64'(q[0].inst));
      chk({ph, " out_br"}, 64'(bus.out_br_taken), 64'(q[0].br));
    end else begin
      chk({ph, " out_pc"}, 64'(bus.out_pc), 64'(0));
      chk({ph, " out_inst"}, 64'(bus.out_inst), 64'(NOP));
      chk({ph, " out_br"}, 64'(bus.out_br_taken), 64'(0));
    end
  endtask

  // Called just after a falling edge; ends just after the next one.
  task automatic cycle(bit v, logic [31:0] pc, logic [31:0] inst,
                       bit br, bit rdy, bit fl);
    int   n;
    bit   do_pop;
    bit   do_push;
    ent_t e;
    bus.in_valid    = v;
    bus.in_pc       = pc;
    bus.in_inst     = inst;
    bus.in_br_taken = br;
    bus.out_ready   = rdy;
    bus.flush       = fl;
    #1;
    check_all("pre");
    if (bus.out_valid && rdy && !fl) popped.push_back(bus.out_pc);
    n = q.size();
    if (fl) begin
      q.delete();
    end else begin
      do_pop  = (n > 0) && rdy;
      do_push = v && (n < DEPTH);
      if (do_pop) void'(q.pop_front());
      if (do_push) begin
        e.pc = pc; e.inst = inst; e.br = br;
        q.push_back(e);
      end
    end
    @(posedge clk);
    @(negedge clk);
    check_all("post");
  endtask

  task automatic idle();
    cycle(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    cmp = 0;
    err = 0;
    rst_n = 1'b0;
    bus.in_valid = 0; bus.in_pc = 0; bus.in_inst = 0;
    bus.in_br_taken = 0; bus.out_ready = 0; bus.flush = 0;
    #12;
    @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;

    // Async reset with 3 entries held, no clock edge involved.
    for (int i = 0; i < 3; i++)
      cycle(1, 32'h80 + 4 * i, 32'h1000 + i, i[0], 0, 0);
    #1;
    rst_n = 1'b0;
    #1;
    q.delete();
    chk("rst count", 64'(bus.count), 0);
    chk("rst out_valid", 64'(bus.out_valid), 0);
    chk("rst in_ready", 64'(bus.in_ready), 1);
    chk("rst out_inst", 64'(bus.out_inst), 64'(NOP));
    @(negedge clk);
    rst_n = 1'b1;

    // Empty-to-head latency: the pre-edge check sees an empty buffer.
    cycle(1, 32'h40, 32'h0050_0093, 1, 0, 0);
    chk("lat inst", 64'(bus.out_inst), 64'h0050_0093);
    chk("lat valid", 64'(bus.out_valid), 1);
    cycle(0, 0, 0, 0, 1, 0);

    // Fill and stall.
    for (int i = 0; i < 4; i++)
      cycle(1, 32'h100 + 4 * i, 32'h2000 + i, 0, 0, 0);
    chk("full in_ready", 64'(bus.in_ready), 0);
    chk("full count", 64'(bus.count), 4);
    chk("full almost_full", 64'(bus.almost_full), 1);
    cycle(1, 32'h110, 32'h2004, 0, 0, 0);
    chk("refused count", 64'(bus.count), 4);
    for (int i = 0; i < 4; i++) begin
      chk("drain pc", 64'(bus.out_pc), 64'(32'h100 + 4 * i));
      cycle(0, 0, 0, 0, 1, 0);
    end
    chk("drained", 64'(bus.out_valid), 0);

    // Simultaneous push/pop at count 2 and at count 4.
    cycle(1, 32'h500, 32'h11, 0, 0, 0);
    cycle(1, 32'h504, 32'h12, 0, 0, 0);
    cycle(1, 32'h508, 32'h13, 0, 1, 0);
    chk("pp2 count", 64'(bus.count), 2);
    chk("pp2 head", 64'(bus.out_pc), 64'h504);
    cycle(1, 32'h50C, 32'h14, 0, 0, 0);
    cycle(1, 32'h510, 32'h15, 0, 0, 0);
    cycle(1, 32'h514, 32'h16, 0, 1, 0);
    chk("pp4 count", 64'(bus.count), 3);
    chk("pp4 head", 64'(bus.out_pc), 64'h508);

    // Flush with a concurrent push.
    cycle(0, 0, 0, 0, 1, 0);
    chk("pre flush count", 64'(bus.count), 2);
    cycle(1, 32'h180, 32'h21, 0, 0, 0);
    cycle(1, 32'h200, 32'h22, 1, 1, 1);
    chk("flush count", 64'(bus.count), 0);
    chk("flush valid", 64'(bus.out_valid), 0);
    chk("flush inst", 64'(bus.out_inst), 64'(NOP));
    cycle(1, 32'h204, 32'h23, 0, 0, 0);
    chk("post flush head", 64'(bus.out_pc), 64'h204);
    cycle(0, 0, 0, 0, 1, 0);

    // Wrap-around stream with out_ready toggling every cycle.
    popped.delete();
    begin
      int sent;
      int t;
      sent = 0;
      t = 0;
      while ((sent < 10 || q.size() != 0) && t < 100) begin
        if (sent < 10 && q.size() < DEPTH) begin
          cycle(1, 32'h300 + 4 * sent, 32'h3000 + sent, 0, t[0], 0);
          sent++;
        end else begin
          cycle(0, 0, 0, 0, t[0], 0);
        end
        t++;
      end
      chk("wrap timeout", 64'(t < 100), 1);
    end
    chk("wrap n", 64'(popped.size()), 10);
    for (int i = 0; i < 10 && i < popped.size(); i++)
      chk("wrap pc", 64'(popped[i]), 64'(32'h300 + 4 * i));

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 3) != 0,
            $urandom & 32'hFFFF_FFFC, $urandom,
            1'($urandom), 1'($urandom),
            $urandom_range(0, 24) == 0);
    end
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end
endmodule

// File: doc/id_inst_buffer.md
# id_inst_buffer

Parametrised fetch-to-decode instruction buffer that sits between the instruction fetch/select logic and the decode stage. It replaces the single stall-held pipeline register with a DEPTH-entry FIFO of {pc, inst, br_taken} under a valid/ready handshake. Fetch can run ahead while decode is stalled, and a flush drops all buffered entries in one cycle. When the buffer is empty it presents a NOP to decode.

## Interface
Parameters:
- XLEN, 32, width of pc fields
- DEPTH, 4, number of entries; power of two, >= 2
- NOP_INST, 32'h0000_0013, instruction driven on out_inst when empty

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  fetch presents an entry
- in_ready  out  1  buffer can accept an entry this cycle
- in_pc  in  XLEN  pc of the incoming instruction
- in_inst  in  32  incoming instruction word
- in_br_taken  in  1  fetch-side prediction flag for the incoming instruction
- out_valid  out  1  head entry is valid
- out_ready  in  1  decode consumes the head this cycle (low = decode stall)
- out_pc  out  XLEN  head pc
- out_inst  out  32  head instruction
- out_br_taken  out  1  head prediction flag
- flush  in  1  synchronous flush (writeback redirect); discards all entries
- count  out  $clog2(DEPTH+1)  number of valid entries
- almost_full  out  1  count >= DEPTH-1

## Operation
- Storage: DEPTH entries of {pc, inst, br_taken}, plus a write pointer and a read pointer, each $clog2(DEPTH) bits.
  - Pointers wrap naturally modulo DEPTH.
  - count is kept as an explicit register.
- Push occurs when in_valid && in_ready: the entry is written at the write pointer, and the write pointer increments.
- Pop occurs when out_valid && out_ready: the read pointer increments.
- in_ready = (count != DEPTH).
  - This depends only on registered state, never on out_ready.
  - A push is refused while full, even if a pop happens in the same cycle.
- out_valid = (count != 0).
- Outputs:
  - When out_valid = 1, out_pc, out_inst and out_br_taken show the entry at the read pointer.
  - When out_valid = 0, they are forced to out_pc = 0, out_inst = NOP_INST and out_br_taken = 0.
- count update per cycle:
  - push and pop in the same cycle: unchanged.
  - push only: +1.
  - pop only: -1.
  - neither: unchanged.
- flush has priority over push and pop. In that cycle:
  - both pointers and count go to 0;
  - any push in the same cycle is discarded;
  - any pop in the same cycle is ignored.
- Storage contents are not cleared by reset or flush. Only the pointers and count are reset.
- Asynchronous reset (rst_n = 0) immediately forces pointers and count to 0. Resulting outputs:
  - out_valid = 0, in_ready = 1, almost_full = 0, count = 0;
  - out_inst = NOP_INST, out_pc = 0, out_br_taken = 0.
- Reset release is synchronous in effect: the first push can be accepted on the first rising edge after rst_n goes high.

## Timing
- Latency: no fall-through bypass. An entry pushed at edge N is visible on out_* after edge N, i.e. in the cycle following the push.
- Throughput: one push and one pop per cycle sustained at any count, including count = 0 (push-only) and count = DEPTH (pop-only).
- in_ready, out_valid, count and almost_full are functions of registered state only.
- out_pc, out_inst and out_br_taken are a read mux on registered state; there is no combinational path from any input to any output.
- Flush asserted in cycle N: out_valid = 0 and out_inst = NOP_INST from edge N onward. A push in cycle N+1 is accepted normally.
- Reset asserted mid-operation (non-empty, mid-wrap): all outputs reach their reset values without waiting for a clock edge.

## Test plan
- Reset: rst_n low with the buffer holding 3 entries -> without a clock edge: count = 0, out_valid = 0, in_ready = 1, out_inst = 32'h0000_0013.
- Fill and stall (DEPTH = 4): push pc 0x100..0x10C with out_ready = 0.
  - After 4 pushes: in_ready = 0, count = 4, almost_full = 1.
  - A 5th push attempt (pc 0x110) is refused.
  - Then assert out_ready: outputs are 0x100, 0x104, 0x108, 0x10C in order.
- Simultaneous push/pop at count = 2: count stays 2 and the head advances to the next pc. At count = 4 with push and pop together: the pop occurs, the push is refused, count = 3.
- Flush with push: buffer holds 3 entries; in the same cycle assert flush with in_valid (pc 0x200).
  - Next cycle: count = 0, out_valid = 0, out_inst = NOP; pc 0x200 is absent.
  - A following push of 0x204 appears at the head one cycle later.
- Wrap-around: stream 10 entries with out_ready toggled 1/0 every cycle -> all 10 pcs emerge in order with no loss or duplication, and count never exceeds 4.
- Empty-to-head latency: on an empty buffer, push inst 32'h0050_0093 at edge N -> out_valid = 1 with that inst after edge N, never in the same cycle as the push.
